spi_master_mcs: RTL and testbench
=================================

Name: spi_master_mcs

Overview:
- Parametrised successor to the fixed single-purpose SPI masters (dac, pll, ad9361) in the Nios control system.
- A single command-driven SPI engine serving NUM_SS slaves, with these properties:
  - per-command transfer length, CPOL/CPHA mode and slave select;
  - optional chip-select hold across words, for multi-word register accesses.
- Sits between a CPU-side command/response interface and the board SPI pins. It replaces separate per-device SPI cores.

Parameters:
- NUM_SS, 2, number of slave selects (1..16); SS_W = max(1, clog2(NUM_SS)).
- DATA_W, 16, max bits per transfer; power of two, 2..32; LEN_W = clog2(DATA_W).
- CLK_DIV, 4, clk_clk cycles per SCLK half-period (>=1).

Ports:
- clk_clk  in  1  system clock; all logic on rising edge.
- reset_reset  in  1  synchronous active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  engine accepts command this cycle.
- cmd_data  in  DATA_W  transmit word, right-aligned.
- cmd_len  in  LEN_W  bits to transfer minus one (N = cmd_len+1).
- cmd_ss  in  SS_W  slave index.
- cmd_cpol  in  1  SCLK idle level.
- cmd_cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge.
- cmd_keep_ss  in  1  keep SS asserted after this word.
- rsp_valid  out  1  one-cycle pulse; rsp_data valid.
- rsp_data  out  DATA_W  received word, right-aligned, upper bits zero.
- busy  out  1  state != IDLE.
- SCLK  out  1  SPI clock.
- MOSI  out  1  SPI data out.
- MISO  in  1  SPI data in; already synchronised at top level.
- SS_n  out  NUM_SS  active-low selects.

Behaviour:
- Reset, synchronous, dominates everything:
  - SCLK=0, MOSI=0, SS_n all 1, cmd_ready=0, rsp_valid=0, rsp_data=0, busy=0.
  - Held chip select is dropped.
  - State goes to IDLE; cmd_ready=1 from the first cycle after reset deasserts.
- Handshake:
  - Accept on cmd_valid && cmd_ready. cmd_ready=1 only in IDLE.
  - All cmd_* fields are latched at acceptance; later changes are ignored.
- FSM states: IDLE, SWITCH, SETUP, XFER, HOLD, GAP. Every non-IDLE state except XFER lasts exactly CLK_DIV cycles.
- IDLE -> SWITCH on accept, only if SS is currently held and cmd_ss differs from the held index. SWITCH deasserts all SS_n for CLK_DIV cycles, then goes to SETUP.
- IDLE -> SETUP on any other accept.
  - SETUP drives SS_n[cmd_ss]=0 and SCLK=cmd_cpol.
  - With CPHA=0, MOSI=cmd_data[N-1] from SETUP entry.
- XFER lasts 2N half-periods of CLK_DIV cycles; SCLK toggles at each half-period boundary.
  - CPHA=0: sample MISO at leading edges; shift MOSI to the next bit at trailing edges, except after the last bit.
  - CPHA=1: drive MOSI at leading edges (first bit at the first leading edge); sample MISO at trailing edges.
  - Bits are sent MSB-first from bit N-1 down to 0. The received bit shifts into rsp_data bit 0.
- XFER -> HOLD: SCLK back at CPOL, SS still low.
- HOLD -> GAP if keep_ss=0; GAP has all SS_n=1.
- HOLD -> IDLE directly if keep_ss=1; the held index is recorded.
- On entry to IDLE:
  - rsp_valid=1 for one cycle, concurrent with cmd_ready=1.
  - rsp_data updates on the same edge and holds until the next response.
- Latency, accept edge to rsp_valid edge:
  - keep_ss=0: (2N+3)*CLK_DIV cycles.
  - keep_ss=1: (2N+2)*CLK_DIV cycles.
  - Add CLK_DIV if SWITCH is entered.
- Out-of-range cmd_ss (>= NUM_SS): the transfer runs with no SS asserted and rsp_data = sampled MISO.
- keep_ss on an out-of-range index: nothing is held.
- MOSI holds its last value when idle. SCLK holds the CPOL of the last command.

Test Plan:
- CLK_DIV=2, cmd_len=7, data 0xA5, ss=0, CPOL=0/CPHA=0, MISO driven 0x3C:
  - MOSI edges show 10100101 and rsp_data=0x003C.
  - rsp_valid 38 cycles after accept; SS_n[0] low for 36 cycles.
- All four CPOL/CPHA modes at cmd_len=15, data 0x1234, MISO loopback:
  - rsp_data=0x1234 in every mode.
  - Idle SCLK equals CPOL; sampling edge matches CPHA.
- Two words on ss=1:
  - First word keep_ss=1: SS_n[1] stays low between words.
  - Second word keep_ss=0: SS_n deasserts after the second word's HOLD.
- keep_ss=1 on ss=0, then a command on ss=1:
  - SS_n=all 1 for exactly CLK_DIV cycles before SS_n[1] falls.
  - Latency is one CLK_DIV longer.
- Reset asserted mid-XFER:
  - Next cycle shows SS_n all 1, SCLK=0, busy=0, no rsp_valid.
  - cmd_ready=1 the cycle after reset releases.
- cmd_ss=3 with NUM_SS=2: all SS_n stay 1 and rsp_valid still pulses. cmd_valid held while busy: no second accept until IDLE.

Source files
------------

// File: rtl/spi_master_mcs.sv
// spi_master_mcs: command-driven multi-slave SPI master with per-command length, mode and chip-select hold
module spi_master_mcs #(
    parameter int NUM_SS  = 2,
    parameter int DATA_W  = 16,
    parameter int CLK_DIV = 4,
    localparam int SS_W   = (NUM_SS > 1) ? $clog2(NUM_SS) : 1,
    localparam int LEN_W  = $clog2(DATA_W)
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [SS_W-1:0]   cmd_ss,
    input  logic              cmd_cpol,
    input  logic              cmd_cpha,
    input  logic              cmd_keep_ss,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic              SCLK,
    output logic              MOSI,
    input  logic              MISO,
    output logic [NUM_SS-1:0] SS_n
);
    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {IDLE, SWITCH, SETUP, XFER, HOLD, GAP} state_t;

    state_t            r_state, w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [LEN_W:0]    r_half;
    logic [DATA_W-1:0] r_tx, r_rx, r_rsp_data;
    logic [LEN_W-1:0]  r_len;
    logic [SS_W-1:0]   r_ss;
    logic              r_cpha, r_keep, r_held, r_mosi, r_sclk, r_rsp_valid;
    logic              w_accept, w_tick, w_last, w_sel, w_done;
    logic [DATA_W-1:0] w_tx_align;
    logic [NUM_SS-1:0] w_onehot;

    assign cmd_ready  = (r_state == IDLE) && !reset_reset;
    assign w_accept   = cmd_valid && cmd_ready;
    assign w_tick     = r_cnt == CNT_W'(CLK_DIV - 1);
    assign w_last     = r_half == {r_len, 1'b1};
    assign w_done     = (r_state != IDLE) && (w_next == IDLE);
    assign w_tx_align = cmd_data << (LEN_W'(DATA_W - 1) - cmd_len);
    assign w_sel      = (r_state inside {SETUP, XFER, HOLD}) || (r_state == IDLE && r_held);
    assign SS_n       = w_sel ? ~w_onehot : '1;
    assign SCLK       = r_sclk;
    assign MOSI       = r_mosi;
    assign busy       = r_state != IDLE;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_data   = r_rsp_data;

    // Decode the latched slave index; out-of-range indices select nobody
    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < NUM_SS; i++)
            w_onehot[i] = r_ss == SS_W'(i);
    end

    // State register
    always_ff @(posedge clk_clk)
        r_state <= reset_reset ? IDLE : w_next;

    // Next-state: every timed state ends on a divider tick, XFER after 2N half-periods
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = (r_held && cmd_ss != r_ss) ? SWITCH : SETUP;
            SWITCH:  if (w_tick) w_next = SETUP;
            SETUP:   if (w_tick) w_next = XFER;
            XFER:    if (w_tick && w_last) w_next = HOLD;
            HOLD:    if (w_tick) w_next = r_keep ? IDLE : GAP;
            GAP:     if (w_tick) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Datapath: command latch, half-period divider, SCLK/MOSI generation, MISO capture, response
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_cnt       <= '0;
            r_half      <= '0;
            r_tx        <= '0;
            r_rx        <= '0;
            r_len       <= '0;
            r_ss        <= '0;
            r_cpha      <= 1'b0;
            r_keep      <= 1'b0;
            r_held      <= 1'b0;
            r_mosi      <= 1'b0;
            r_sclk      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_cnt       <= (r_state == IDLE || w_tick) ? '0 : r_cnt + 1'b1;
            r_rsp_valid <= w_done;
            if (w_done)
                r_rsp_data <= r_rx;
            if (w_accept) begin
                r_tx   <= (w_next == SETUP && !cmd_cpha) ? w_tx_align << 1 : w_tx_align;
                r_rx   <= '0;
                r_half <= '0;
                r_len  <= cmd_len;
                r_ss   <= cmd_ss;
                r_cpha <= cmd_cpha;
                r_keep <= cmd_keep_ss;
                r_held <= 1'b0;
                r_sclk <= cmd_cpol;
                if (w_next == SETUP && !cmd_cpha)
                    r_mosi <= w_tx_align[DATA_W-1];
            end
            // CPHA=0 presents the first bit before the first SCLK edge
            if (r_state == SWITCH && w_tick && !r_cpha) begin
                r_mosi <= r_tx[DATA_W-1];
                r_tx   <= r_tx << 1;
            end
            // Even half-period ends are leading edges, odd ones trailing
            if (r_state == XFER && w_tick) begin
                r_half <= r_half + 1'b1;
                r_sclk <= ~r_sclk;
                if (r_half[0] == r_cpha)
                    r_rx <= {r_rx[DATA_W-2:0], MISO};
                if (r_half[0] != r_cpha && !w_last) begin
                    r_mosi <= r_tx[DATA_W-1];
                    r_tx   <= r_tx << 1;
                end
            end
            if (r_state == HOLD && w_tick && r_keep)
                r_held <= {1'b0, r_ss} < (SS_W + 1)'(NUM_SS);
        end
    end
endmodule

// File: tb/tb_spi_master_mcs.sv
// tb_spi_master_mcs: directed scenario tests for the SPI master
module tb_spi_master_mcs;
    logic        clk = 1'b0;
    logic        rst, cmd_valid, cmd_ready, cmd_cpol, cmd_cpha, cmd_keep_ss;
    logic [15:0] cmd_data, rsp_data;
    logic [3:0]  cmd_len;
    logic [1:0]  cmd_ss;
    logic        rsp_valid, busy, sclk, mosi, miso;
    logic [2:0]  ss_n;

    int n_vec = 0, n_err = 0;
    int hi_total = 0, lo0_total = 0, lo1_total = 0, acc_total = 0, neg_total = 0;
    int lat, d_hi, d_lo0, d_lo1, neg_base = 0, slv_idx;
    logic [15:0] cap_pos = '0, cap_neg = '0;
    logic [7:0]  pat = '0;
    logic        loop = 1'b1, slv_bit;

    always #5 clk = ~clk;

    spi_master_mcs #(.NUM_SS(3), .DATA_W(16), .CLK_DIV(2)) dut (
        .clk_clk(clk), .reset_reset(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_data(cmd_data), .cmd_len(cmd_len), .cmd_ss(cmd_ss), .cmd_cpol(cmd_cpol),
        .cmd_cpha(cmd_cpha), .cmd_keep_ss(cmd_keep_ss), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .busy(busy), .SCLK(sclk), .MOSI(mosi), .MISO(miso), .SS_n(ss_n)
    );

    // Simple slave: presents pat MSB-first, advancing on each falling SCLK edge
    always_comb begin
        slv_idx = neg_total - neg_base;
        slv_bit = (slv_idx >= 0 && slv_idx < 8) ? pat[7 - slv_idx] : 1'b0;
    end
    assign miso = loop ? mosi : slv_bit;

    always @(negedge clk) begin
        if (ss_n == 3'b111) hi_total++;
        if (!ss_n[0]) lo0_total++;
        if (!ss_n[1]) lo1_total++;
        if (cmd_valid && cmd_ready) acc_total++;
    end
    always @(posedge sclk) cap_pos <= {cap_pos[14:0], mosi};
    always @(negedge sclk) begin
        cap_neg   <= {cap_neg[14:0], mosi};
        neg_total <= neg_total + 1;
    end

    task automatic wait_rsp();
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (!rsp_valid && lat < 500);
        if (!rsp_valid) begin
            n_vec++; n_err++;
            $display("FAIL rsp_timeout: rsp_valid=0 after %0d cycles, required 1", lat);
        end
    endtask

    task automatic send(input logic [15:0] d, input logic [3:0] l, input logic [1:0] s,
                        input logic pol, input logic pha, input logic keep);
        int c, s_hi, s_lo0, s_lo1;
        c = 0;
        while (!cmd_ready && c < 500) begin
            @(posedge clk); #1; c++;
        end
        cmd_data = d; cmd_len = l; cmd_ss = s; cmd_cpol = pol; cmd_cpha = pha; cmd_keep_ss = keep;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        s_hi = hi_total; s_lo0 = lo0_total; s_lo1 = lo1_total;
        wait_rsp();
        d_hi = hi_total - s_hi; d_lo0 = lo0_total - s_lo0; d_lo1 = lo1_total - s_lo1;
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; cmd_data = '0; cmd_len = '0; cmd_ss = '0;
        cmd_cpol = 1'b0; cmd_cpha = 1'b0; cmd_keep_ss = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (ss_n !== 3'b111) begin n_err++; $display("FAIL reset_ss_n: got %b want 111", ss_n); end
        n_vec++; if (sclk !== 1'b0) begin n_err++; $display("FAIL reset_sclk: got %b want 0", sclk); end
        n_vec++; if (mosi !== 1'b0) begin n_err++; $display("FAIL reset_mosi: got %b want 0", mosi); end
        n_vec++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", cmd_ready); end
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        n_vec++; if (rsp_data !== 16'h0) begin n_err++; $display("FAIL reset_rsp_data: got %h want 0000", rsp_data); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst = 1'b0;
        @(posedge clk); #1;
        n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_ready: got %b want 1", cmd_ready); end
    endtask

    task automatic test_basic();
        loop = 1'b0; pat = 8'h3C; neg_base = neg_total;
        send(16'h00A5, 4'd7, 2'd0, 1'b0, 1'b0, 1'b0);
        loop = 1'b1;
        n_vec++; if (lat !== 38) begin n_err++; $display("FAIL basic_latency: got %0d want 38", lat); end
        n_vec++; if (rsp_data !== 16'h003C) begin n_err++; $display("FAIL basic_rsp: got %h want 003c", rsp_data); end
        n_vec++; if (cap_pos[7:0] !== 8'hA5) begin n_err++; $display("FAIL basic_mosi: got %h want a5", cap_pos[7:0]); end
        n_vec++; if (d_lo0 !== 36) begin n_err++; $display("FAIL basic_ss0_low: got %0d want 36", d_lo0); end
        n_vec++; if (ss_n !== 3'b111) begin n_err++; $display("FAIL basic_ss_idle: got %b want 111", ss_n); end
    endtask

    task automatic test_modes();
        for (int m = 0; m < 4; m++) begin
            logic pol, pha;
            pol = m[1]; pha = m[0];
            send(16'h1234, 4'd15, 2'd0, pol, pha, 1'b0);
            n_vec++; if (rsp_data !== 16'h1234) begin n_err++; $display("FAIL mode%0d_rsp: got %h want 1234", m, rsp_data); end
            n_vec++; if (lat !== 70) begin n_err++; $display("FAIL mode%0d_latency: got %0d want 70", m, lat); end
            n_vec++; if (sclk !== pol) begin n_err++; $display("FAIL mode%0d_idle_sclk: got %b want %b", m, sclk, pol); end
            n_vec++;
            if (((pol ^ pha) ? cap_neg : cap_pos) !== 16'h1234) begin
                n_err++; $display("FAIL mode%0d_sample_edge: got %h want 1234", m, (pol ^ pha) ? cap_neg : cap_pos);
            end
        end
    endtask

    task automatic test_keep();
        send(16'h00F0, 4'd7, 2'd1, 1'b0, 1'b0, 1'b1);
        n_vec++; if (lat !== 36) begin n_err++; $display("FAIL keep_latency1: got %0d want 36", lat); end
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (ss_n !== 3'b101) begin n_err++; $display("FAIL keep_held: got %b want 101", ss_n); end
        send(16'h000F, 4'd7, 2'd1, 1'b0, 1'b0, 1'b0);
        n_vec++; if (lat !== 38) begin n_err++; $display("FAIL keep_latency2: got %0d want 38", lat); end
        n_vec++; if (d_hi !== 2) begin n_err++; $display("FAIL keep_gap: got %0d want 2", d_hi); end
        n_vec++; if (rsp_data !== 16'h000F) begin n_err++; $display("FAIL keep_rsp: got %h want 000f", rsp_data); end
        n_vec++; if (ss_n !== 3'b111) begin n_err++; $display("FAIL keep_release: got %b want 111", ss_n); end
    endtask

    task automatic test_switch();
        send(16'h0033, 4'd7, 2'd0, 1'b0, 1'b0, 1'b1);
        n_vec++; if (ss_n !== 3'b110) begin n_err++; $display("FAIL switch_held0: got %b want 110", ss_n); end
        send(16'h00C3, 4'd7, 2'd1, 1'b0, 1'b0, 1'b0);
        n_vec++; if (lat !== 40) begin n_err++; $display("FAIL switch_latency: got %0d want 40", lat); end
        n_vec++; if (d_hi !== 4) begin n_err++; $display("FAIL switch_all_high: got %0d want 4", d_hi); end
        n_vec++; if (d_lo1 !== 36) begin n_err++; $display("FAIL switch_ss1_low: got %0d want 36", d_lo1); end
        n_vec++; if (d_lo0 !== 0) begin n_err++; $display("FAIL switch_ss0_low: got %0d want 0", d_lo0); end
    endtask

    task automatic test_oob();
        int s_acc, s_hi;
        cmd_data = 16'h005A; cmd_len = 4'd7; cmd_ss = 2'd3; cmd_cpol = 1'b0; cmd_cpha = 1'b0; cmd_keep_ss = 1'b1;
        s_acc = acc_total;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        s_hi = hi_total;
        wait_rsp();
        n_vec++; if (lat !== 36) begin n_err++; $display("FAIL oob_latency: got %0d want 36", lat); end
        n_vec++; if (hi_total - s_hi !== 36) begin n_err++; $display("FAIL oob_no_select: got %0d want 36", hi_total - s_hi); end
        n_vec++; if (rsp_data !== 16'h005A) begin n_err++; $display("FAIL oob_rsp: got %h want 005a", rsp_data); end
        n_vec++; if (acc_total - s_acc !== 1) begin n_err++; $display("FAIL busy_single_accept: got %0d want 1", acc_total - s_acc); end
        n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL rsp_with_ready: got %b want 1", cmd_ready); end
        @(posedge clk); #1;
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL held_valid_reaccept: got %b want 1", busy); end
        wait_rsp();
        cmd_valid = 1'b0;
        n_vec++; if (acc_total - s_acc !== 2) begin n_err++; $display("FAIL busy_accept_count: got %0d want 2", acc_total - s_acc); end
        send(16'h0081, 4'd7, 2'd0, 1'b0, 1'b0, 1'b0);
        n_vec++; if (lat !== 38) begin n_err++; $display("FAIL oob_not_held: got %0d want 38", lat); end
    endtask

    task automatic test_reset_mid();
        logic rv;
        cmd_data = 16'hFFFF; cmd_len = 4'd15; cmd_ss = 2'd0; cmd_cpol = 1'b1; cmd_cpha = 1'b0; cmd_keep_ss = 1'b0;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        n_vec++; if (ss_n !== 3'b111) begin n_err++; $display("FAIL midrst_ss_n: got %b want 111", ss_n); end
        n_vec++; if (sclk !== 1'b0) begin n_err++; $display("FAIL midrst_sclk: got %b want 0", sclk); end
        n_vec++; if (mosi !== 1'b0) begin n_err++; $display("FAIL midrst_mosi: got %b want 0", mosi); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b want 0", busy); end
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL midrst_rsp_valid: got %b want 0", rsp_valid); end
        n_vec++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL midrst_ready_in_reset: got %b want 0", cmd_ready); end
        rst = 1'b0;
        @(posedge clk); #1;
        n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL midrst_ready_after: got %b want 1", cmd_ready); end
        rv = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (rsp_valid) rv = 1'b1;
        end
        n_vec++; if (rv !== 1'b0) begin n_err++; $display("FAIL midrst_no_rsp: got %b want 0", rv); end
        n_vec++; if (rsp_data !== 16'h0) begin n_err++; $display("FAIL midrst_rsp_data: got %h want 0000", rsp_data); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_modes();
        test_keep();
        test_switch();
        test_oob();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
